// File: rtl/decode_if.sv
// Handshake and decoded-bundle signals between fetch, the decode stage and execute.
// The decode stage is the slave; the fetch/execute environment is the master.
interface decode_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [XLEN-1:0]  imm;
  logic [2:0]       alu_ctrl;
  logic             alu_src_imm;
  logic             reg_write_enable;
  logic             reg_write_select;
  logic             data_write_enable;
  logic             is_load;
  logic [1:0]       branch;
  logic             illegal;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_ctrl, alu_src_imm,
           reg_write_enable, reg_write_select, data_write_enable, is_load, branch,
           illegal, stall_count
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_ctrl, alu_src_imm,
           reg_write_enable, reg_write_select, data_write_enable, is_load, branch,
           illegal, stall_count
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV64I-subset decode stage: combinational decode into a one-deep output
// register, with load-use bubble insertion, flush and a saturating stall counter.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic    clk,
  input  logic    reset,
  decode_if.slave bus
);
  typedef enum logic [2:0] {ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_ADD = 3'd2, ALU_SUB = 3'd3} alu_e;
  typedef enum logic [1:0] {NO_JUMP = 2'd0, BR_EQ = 2'd1, BR_LT = 2'd2} br_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    alu_e            alu;
    logic            src_imm;
    logic            rwe;
    logic            rws;
    logic            dwe;
    logic            ld;
    br_e             br;
    logic            ill;
  } bundle_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0]      inst;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [XLEN-1:0]  imm_i, imm_s, imm_b;
  alu_e             f3_alu;
  logic             f3_ok;
  bundle_t          dec;
  logic             uses_rs1, uses_rs2;
  logic             hazard, accept, stall_event;
  logic             valid_d, valid_q;
  bundle_t          bundle_d, bundle_q;
  logic [CNT_W-1:0] stall_d, stall_q;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

  // funct3 selects the same operation for R-type and I-type ALU instructions
  always_comb begin
    f3_alu = ALU_AND;
    f3_ok  = 1'b1;
    case (funct3)
      3'b000:  f3_alu = ALU_ADD;
      3'b110:  f3_alu = ALU_OR;
      3'b111:  f3_alu = ALU_AND;
      default: f3_ok  = 1'b0;
    endcase
  end

  always_comb begin
    dec      = '0;
    dec.pc   = bus.in_pc;
    dec.rs1  = inst[19:15];
    dec.rs2  = inst[24:20];
    dec.rd   = inst[11:7];
    dec.alu  = ALU_AND;
    dec.br   = NO_JUMP;
    dec.ill  = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_LOAD: if (funct3 == 3'b011) begin
        dec.ill = 1'b0; dec.rwe = 1'b1; dec.ld = 1'b1;
        dec.alu = ALU_ADD; dec.src_imm = 1'b1; dec.imm = imm_i;
      end
      OP_STORE: if (funct3 == 3'b011) begin
        dec.ill = 1'b0; dec.dwe = 1'b1; dec.alu = ALU_ADD;
        dec.src_imm = 1'b1; dec.imm = imm_s; uses_rs2 = 1'b1;
      end
      OP_REG: begin
        dec.rwe  = 1'b1;
        dec.rws  = 1'b1;
        uses_rs2 = 1'b1;
        if (funct7 == 7'b0000000 && f3_ok) begin
          dec.ill = 1'b0; dec.alu = f3_alu;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.ill = 1'b0; dec.alu = ALU_SUB;
        end
      end
      OP_IMM: if (f3_ok) begin
        dec.ill = 1'b0; dec.rwe = 1'b1; dec.rws = 1'b1;
        dec.alu = f3_alu; dec.src_imm = 1'b1; dec.imm = imm_i;
      end
      OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b100) begin
        dec.ill = 1'b0; dec.alu = ALU_SUB; dec.imm = imm_b; uses_rs2 = 1'b1;
        dec.br  = funct3[2] ? BR_LT : BR_EQ;
      end
      default: ;
    endcase
    // partially matched encodings must not leak enables or an immediate
    if (dec.ill) begin
      dec.imm     = '0;
      dec.alu     = ALU_AND;
      dec.src_imm = 1'b0;
      dec.rwe     = 1'b0;
      dec.rws     = 1'b0;
      dec.dwe     = 1'b0;
      dec.ld      = 1'b0;
      dec.br      = NO_JUMP;
      uses_rs2    = 1'b0;
    end
    uses_rs1 = !dec.ill;
  end

  assign hazard = valid_q && bundle_q.ld && (bundle_q.rd != 5'd0) &&
                  ((uses_rs1 && dec.rs1 == bundle_q.rd) || (uses_rs2 && dec.rs2 == bundle_q.rd));

  assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign stall_event  = bus.in_valid && hazard && bus.out_ready && !bus.flush;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    stall_d  = stall_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
    if (stall_event && stall_q != {CNT_W{1'b1}}) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      stall_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.out_valid         = valid_q;
  assign bus.out_pc            = bundle_q.pc;
  assign bus.rs1               = bundle_q.rs1;
  assign bus.rs2               = bundle_q.rs2;
  assign bus.rd                = bundle_q.rd;
  assign bus.imm               = bundle_q.imm;
  assign bus.alu_ctrl          = bundle_q.alu;
  assign bus.alu_src_imm       = bundle_q.src_imm;
  assign bus.reg_write_enable  = bundle_q.rwe;
  assign bus.reg_write_select  = bundle_q.rws;
  assign bus.data_write_enable = bundle_q.dwe;
  assign bus.is_load           = bundle_q.ld;
  assign bus.branch            = bundle_q.br;
  assign bus.illegal           = bundle_q.ill;
  assign bus.stall_count       = stall_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic checked against a
// mnemonic-level reference model of the decoder and the one-deep output stage.
module tb_decode_stage;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  decode_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [2:0]  alu;
    logic        src, rwe, rws, dwe, ld;
    logic [1:0]  br;
    logic        ill, u1, u2;
  } exp_t;

  exp_t        m;
  logic [63:0] m_pc;
  bit          m_valid;
  int          m_cnt;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] w, output exp_t e);
    int     op, f3, f7, sw, lo5, b7, mid6, lo4;
    longint imm_i, imm_s, imm_b;
    string  mn;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    sw = $signed(w); lo5 = w[11:7]; b7 = w[7]; mid6 = w[30:25]; lo4 = w[11:8];
    imm_i = sw >>> 20;
    imm_s = (sw >>> 25) * 32 + lo5;
    imm_b = (sw >>> 31) * 4096 + b7 * 2048 + mid6 * 32 + lo4 * 2;
    mn = "illegal";
    if (op == 'h03 && f3 == 3) mn = "ld";
    else if (op == 'h23 && f3 == 3) mn = "sd";
    else if (op == 'h33 && f7 == 0 && f3 == 0) mn = "add";
    else if (op == 'h33 && f7 == 32 && f3 == 0) mn = "sub";
    else if (op == 'h33 && f7 == 0 && f3 == 6) mn = "or";
    else if (op == 'h33 && f7 == 0 && f3 == 7) mn = "and";
    else if (op == 'h13 && f3 == 0) mn = "addi";
    else if (op == 'h13 && f3 == 6) mn = "ori";
    else if (op == 'h13 && f3 == 7) mn = "andi";
    else if (op == 'h63 && f3 == 0) mn = "beq";
    else if (op == 'h63 && f3 == 4) mn = "blt";
    e = '{default: '0};
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    e.u1 = (mn != "illegal");
    case (mn)
      "ld":   begin e.rwe = 1; e.ld = 1; e.alu = 2; e.src = 1; e.imm = imm_i; end
      "sd":   begin e.dwe = 1; e.alu = 2; e.src = 1; e.imm = imm_s; e.u2 = 1; end
      "add":  begin e.rwe = 1; e.rws = 1; e.alu = 2; e.u2 = 1; end
      "sub":  begin e.rwe = 1; e.rws = 1; e.alu = 3; e.u2 = 1; end
      "or":   begin e.rwe = 1; e.rws = 1; e.alu = 1; e.u2 = 1; end
      "and":  begin e.rwe = 1; e.rws = 1; e.alu = 0; e.u2 = 1; end
      "addi": begin e.rwe = 1; e.rws = 1; e.alu = 2; e.src = 1; e.imm = imm_i; end
      "ori":  begin e.rwe = 1; e.rws = 1; e.alu = 1; e.src = 1; e.imm = imm_i; end
      "andi": begin e.rwe = 1; e.rws = 1; e.alu = 0; e.src = 1; e.imm = imm_i; end
      "beq":  begin e.alu = 3; e.br = 1; e.imm = imm_b; e.u2 = 1; end
      "blt":  begin e.alu = 3; e.br = 2; e.imm = imm_b; e.u2 = 1; end
      default: e.ill = 1;
    endcase
  endfunction

  function automatic logic [153:0] pack_exp(input exp_t e, input logic [63:0] pc);
    return {pc, e.rs1, e.rs2, e.rd, e.imm, e.alu, e.src, e.rwe, e.rws, e.dwe, e.ld, e.br, e.ill};
  endfunction

  function automatic logic [153:0] dut_vec();
    return {bus.out_pc, bus.rs1, bus.rs2, bus.rd, bus.imm, bus.alu_ctrl, bus.alu_src_imm,
            bus.reg_write_enable, bus.reg_write_select, bus.data_write_enable, bus.is_load,
            bus.branch, bus.illegal};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_cnt = 0; m_pc = '0; m = '{default: '0};
  endtask

  task automatic cycle(input bit v, input logic [31:0] w, input logic [63:0] pc,
                       input bit rdy, input bit fl, output bit acc);
    exp_t n;
    bit   hz, rdy_exp;
    bus.in_valid = v; bus.in_inst = w; bus.in_pc = pc; bus.out_ready = rdy; bus.flush = fl;
    ref_decode(w, n);
    hz = m_valid && m.ld && m.rd != 0 &&
         ((n.u1 && n.rs1 == m.rd) || (n.u2 && n.rs2 == m.rd));
    rdy_exp = (!m_valid || rdy) && !hz && !fl;
    @(negedge clk);
    chk("in_ready", bus.in_ready, rdy_exp);
    chk("out_valid", bus.out_valid, m_valid);
    if (m_valid) chk("bundle", dut_vec(), pack_exp(m, m_pc));
    chk("stall_count", bus.stall_count, m_cnt);
    @(posedge clk);
    acc = v && rdy_exp;
    if (fl) m_valid = 0;
    else if (acc) begin m = n; m_pc = pc; m_valid = 1; end
    else if (rdy) m_valid = 0;
    if (!fl && v && hz && rdy && m_cnt < CMAX) m_cnt++;
    #1;
  endtask

  task automatic go(input bit v, input logic [31:0] w, input logic [63:0] pc,
                    input bit rdy, input bit fl);
    bit acc;
    cycle(v, w, pc, rdy, fl, acc);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  a, b, c;
    logic [11:0] im;
    logic [31:0] w;
    a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); c = 5'($urandom_range(0, 3));
    im = 12'($urandom);
    case ($urandom_range(0, 12))
      0:  w = {im, b, 3'b011, a, 7'b0000011};
      1:  w = {im[11:5], c, b, 3'b011, im[4:0], 7'b0100011};
      2:  w = {7'b0000000, c, b, 3'b000, a, 7'b0110011};
      3:  w = {7'b0100000, c, b, 3'b000, a, 7'b0110011};
      4:  w = {7'b0000000, c, b, 3'b110, a, 7'b0110011};
      5:  w = {7'b0000000, c, b, 3'b111, a, 7'b0110011};
      6:  w = {im, b, 3'b000, a, 7'b0010011};
      7:  w = {im, b, 3'b110, a, 7'b0010011};
      8:  w = {im, b, 3'b111, a, 7'b0010011};
      9:  w = {im[11:5], c, b, 3'b000, im[4:0], 7'b1100011};
      10: w = {im[11:5], c, b, 3'b100, im[4:0], 7'b1100011};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  localparam logic [31:0] LD  = 32'h0080B283;
  localparam logic [31:0] ADD = 32'h00228333;
  localparam logic [31:0] BEQ = 32'hFE208EE3;
  localparam logic [31:0] ORI = 32'h00506393;

  initial begin
    logic [31:0] cur;
    logic [63:0] cpc;
    bit          have, acc;

    reset = 1'b1;
    bus.in_valid = 0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 0; bus.flush = 0;
    model_reset();
    #3;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_stall", bus.stall_count, 0);
    chk("rst_bundle", dut_vec(), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    go(1, LD, 64'h100, 1, 0);
    chk("ld_valid", bus.out_valid, 1);
    chk("ld_rd", bus.rd, 5);
    chk("ld_rs1", bus.rs1, 1);
    chk("ld_imm", bus.imm, 8);
    chk("ld_flags", {bus.is_load, bus.reg_write_enable, bus.alu_src_imm}, 3'b111);
    chk("ld_alu", bus.alu_ctrl, 2);
    chk("ld_pc", bus.out_pc, 64'h100);

    go(1, ADD, 64'h104, 1, 0);
    chk("bubble_valid", bus.out_valid, 0);
    chk("bubble_cnt", bus.stall_count, 1);
    go(1, ADD, 64'h104, 1, 0);
    chk("add_valid", bus.out_valid, 1);
    chk("add_rd", bus.rd, 6);

    go(1, BEQ, 64'h108, 1, 0);
    chk("beq_branch", bus.branch, 1);
    chk("beq_alu", bus.alu_ctrl, 3);
    chk("beq_imm", bus.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_rwe", bus.reg_write_enable, 0);

    go(1, ADD, 64'h10C, 1, 0);
    repeat (3) begin
      go(1, ORI, 64'h110, 0, 0);
      chk("hold_rd", bus.rd, 6);
      chk("hold_pc", bus.out_pc, 64'h10C);
      chk("hold_cnt", bus.stall_count, 1);
    end
    go(1, ORI, 64'h110, 1, 0);
    chk("release_pc", bus.out_pc, 64'h110);
    chk("ori_imm", bus.imm, 5);

    go(1, 32'h0, 64'h114, 1, 0);
    chk("ill_flag", bus.illegal, 1);
    chk("ill_en", {bus.reg_write_enable, bus.data_write_enable, bus.is_load, bus.branch}, 0);
    go(0, 32'h0, 64'h0, 0, 1);
    chk("flush_valid", bus.out_valid, 0);

    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    repeat (5) begin
      go(1, LD, 64'h200, 1, 0);
      go(1, ADD, 64'h204, 1, 0);
      go(1, ADD, 64'h204, 1, 0);
    end
    chk("five_stalls", bus.stall_count, 5);
    chk("pre_rst_valid", bus.out_valid, 1);
    #3 reset = 1'b1;
    #1;
    chk("async_valid", bus.out_valid, 0);
    chk("async_cnt", bus.stall_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    have = 0; cpc = 64'h1000; cur = '0;
    repeat (800) begin
      if (!have) begin cur = rand_inst(); cpc = cpc + 4; have = 1; end
      cycle($urandom_range(0, 3) != 0, cur, cpc, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, acc);
      if (acc) have = 0;
    end
    chk("sat_cnt", bus.stall_count, m_cnt);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV64I-subset decode stage with valid/ready handshakes on both sides.
- Sits between the fetch stage and the execute/register-read stage.
- Compared with the purely combinational decoder it adds:
  - full sign-extended immediate generation for any XLEN;
  - I-type ALU instructions;
  - illegal-instruction flagging;
  - load-use hazard bubble insertion;
  - pipeline flush;
  - a hazard-stall performance counter.

Parameters:
- XLEN, 64, datapath width for pc and immediate (32 or 64).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard the held instruction and the incoming one this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts an instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction pc.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_pc  out  XLEN  pc of the decoded instruction.
- rs1, rs2, rd  out  5 each  register addresses: inst[19:15], inst[24:20], inst[11:7].
- imm  out  XLEN  sign-extended immediate.
- alu_ctrl  out  3  0=AND, 1=OR, 2=ADD, 3=SUB.
- alu_src_imm  out  1  ALU operand B is imm.
- reg_write_enable  out  1  instruction writes rd.
- reg_write_select  out  1  1 = ALU result, 0 = memory data.
- data_write_enable  out  1  store.
- is_load  out  1  load.
- branch  out  2  0=NO_JUMP, 1=BEQ, 2=BLT.
- illegal  out  1  unrecognised encoding.
- stall_count  out  CNT_W  number of hazard bubbles inserted.

Behaviour:
- Reset (async, active-high): all outputs 0; out_valid=0, stall_count=0, alu_ctrl=AND, branch=NO_JUMP.
- Decode is combinational on in_inst; all out_* are registered. Latency is 1 cycle from the input handshake to out_valid.
- Decode table, keyed on {funct7, funct3, opcode}:
  - ld (011, 0000011): reg_write_enable=1, is_load=1, ADD, alu_src_imm=1, I-immediate.
  - sd (011, 0100011): data_write_enable=1, ADD, alu_src_imm=1, S-immediate.
  - and / or / add / sub (0110011; funct7 0000000 for and/or/add, 0100000 for sub): reg_write_enable=1, reg_write_select=1, alu_ctrl per op.
  - addi / ori / andi (0010011; funct3 000 / 110 / 111): as the R-type op, plus alu_src_imm=1 and I-immediate.
  - beq (000, 1100011): SUB, branch=1, B-immediate.
  - blt (100, 1100011): SUB, branch=2, B-immediate.
  - Anything else: illegal=1, all enables 0, branch=0, alu_ctrl=AND.
- Immediate formats (all sign-extended from inst[31] to XLEN):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - R-type: imm=0.
- Source-use flags:
  - uses_rs1 for every legal instruction.
  - uses_rs2 for R-type, sd, beq and blt only.
- Hazard (combinational): out_valid & is_load & rd!=0 & ((uses_rs1 & rs1_in==rd) | (uses_rs2 & rs2_in==rd)), where rd is the registered output rd.
- Handshake and stage update:
  - in_ready = (!out_valid | out_ready) & !hazard & !flush.
  - On in_valid & in_ready: the output register loads the new bundle with out_valid=1.
  - Else if out_ready: out_valid <= 0.
  - Else: hold all outputs stable; downstream must see no change while out_valid & !out_ready.
- Hazard with out_ready=1 and in_valid=1: insert a bubble (out_valid <= 0 next cycle), keep the instruction at the input, and increment stall_count by 1. The next cycle the hazard has cleared, so the instruction is accepted.
- Hazard with out_ready=0: plain backpressure, no count.
- stall_count saturates at all-ones.
- flush: out_valid <= 0 next cycle regardless of out_ready; in_ready=0 that cycle; no stall counted. flush has priority over accept and hazard.
- Reset mid-transfer: the bundle is dropped; stall_count clears.
- Illegal instructions pass through with out_valid=1 and illegal=1; downstream handles the trap.

Test Plan:
- Reset, then in_inst=0x0080B283 (ld x5,8(x1)), in_pc=0x100, out_ready=1 -> next cycle: out_valid=1, rd=5, rs1=1, imm=8, is_load=1, reg_write_enable=1, alu_src_imm=1, alu_ctrl=2, out_pc=0x100.
- ld as above, followed by 0x00228333 (add x6,x5,x2) -> one bubble cycle with out_valid=0 and in_ready=0; add emerges the cycle after; stall_count=1.
- 0xFE208EE3 (beq x1,x2,-4), XLEN=64 -> branch=1, alu_ctrl=3, imm=0xFFFFFFFFFFFFFFFC, reg_write_enable=0.
- out_ready=0 for 3 cycles with a valid add held -> outputs stable, in_ready=0, stall_count unchanged; release -> next instruction accepted.
- in_inst=0x00000000 -> illegal=1, all enables 0. Then flush asserted while out_ready=0 -> out_valid=0 next cycle.
- Assert reset asynchronously mid-cycle while out_valid=1 and stall_count=5 -> out_valid=0 and stall_count=0 immediately, without waiting for a clk edge.
